fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/cpu_pkg.sv | 15 +
 rtl/fetch_queue.sv | 84 ++++++++
 tb/tb_fetch_queue.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath width, the canonical NOP,
// and the fetch queue entry layout.
package cpu_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage : cpu_pkg

// File: rtl/fetch_queue.sv
// Circular instruction fetch queue between fetch and decode; flush empties it
// synchronously, rst_n empties it asynchronously. No enqueue-to-dequeue bypass.
//
// Handshake: a side transfers on a rising clk edge where its valid and ready are
// both 1 and flush is 0; enq_ready depends only on occupancy (never on deq_ready),
// and deq_valid/deq_pc/deq_instr come straight from the registered head entry.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = cpu_pkg::XLEN
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [XLEN-1:0]          enq_pc,
  input  logic [XLEN-1:0]          enq_instr,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [XLEN-1:0]          deq_pc,
  output logic [XLEN-1:0]          deq_instr,
  output logic [$clog2(DEPTH):0]   count
);
  import cpu_pkg::fetch_entry_t;
  import cpu_pkg::NOP_INSTR;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t    r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  logic            w_full;
  logic            w_empty;
  logic            w_do_enq;
  logic            w_do_deq;
  fetch_entry_t    w_head;
  fetch_entry_t    w_enq_entry;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_do_enq = enq_valid && !w_full  && !flush;
  assign w_do_deq = deq_ready && !w_empty && !flush;

  assign w_enq_entry.pc    = enq_pc;
  assign w_enq_entry.instr = enq_instr;

  // DEPTH is a power of two, so pointer increments wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_enq) r_wptr <= r_wptr + PW'(1);
      if (w_do_deq) r_rptr <= r_rptr + PW'(1);
      case ({w_do_enq, w_do_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; stale slots are hidden behind the occupancy count.
  always_ff @(posedge clk) begin
    if (w_do_enq) r_mem[r_wptr] <= w_enq_entry;
  end

  assign w_head = r_mem[r_rptr];

  assign enq_ready = !w_full;
  assign deq_valid = !w_empty;
  assign count     = r_count;
  assign deq_pc    = w_empty ? '0 : w_head.pc;
  assign deq_instr = w_empty ? XLEN'(NOP_INSTR) : w_head.instr;

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic, checked against
// a queue-based reference model by a negedge monitor.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            enq_valid;
  logic            enq_ready;
  logic [XLEN-1:0] enq_pc;
  logic [XLEN-1:0] enq_instr;
  logic            deq_valid;
  logic            deq_ready;
  logic [XLEN-1:0] deq_pc;
  logic [XLEN-1:0] deq_instr;
  logic [CW-1:0]   count;

  int checks = 0;
  int errors = 0;

  // Expected contents, oldest first: {pc, instr}.
  logic [2*XLEN-1:0] exp_q[$];

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_pc    (enq_pc),
    .enq_instr (enq_instr),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_pc    (deq_pc),
    .deq_instr (deq_instr),
    .count     (count)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  // At each negedge the model holds the state produced by the previous rising
  // edge; compare, then advance the model with the inputs applied for the next edge.
  int                sz;
  logic [2*XLEN-1:0] head;
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_count", 64'(count), 64'd0);
      check("rst_deq_valid", 64'(deq_valid), 64'd0);
      check("rst_enq_ready", 64'(enq_ready), 64'd1);
      check("rst_deq_instr", 64'(deq_instr), 64'(NOP));
      check("rst_deq_pc", 64'(deq_pc), 64'd0);
      exp_q.delete();
    end else begin
      sz = exp_q.size();
      check("count", 64'(count), 64'(sz));
      check("deq_valid", 64'(deq_valid), 64'(sz != 0));
      check("enq_ready", 64'(enq_ready), 64'(sz != DEPTH));
      if (sz == 0) begin
        check("empty_instr", 64'(deq_instr), 64'(NOP));
        check("empty_pc", 64'(deq_pc), 64'd0);
      end else begin
        head = exp_q[0];
        check("head_pc", 64'(deq_pc), 64'(head[2*XLEN-1:XLEN]));
        check("head_instr", 64'(deq_instr), 64'(head[XLEN-1:0]));
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (deq_ready && sz != 0) void'(exp_q.pop_front());
        if (enq_valid && sz != DEPTH) exp_q.push_back({enq_pc, enq_instr});
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic ev, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] ins,
                       input logic dr, input logic fl);
    @(posedge clk);
    #1;
    enq_valid = ev;
    enq_pc    = pc;
    enq_instr = ins;
    deq_ready = dr;
    flush     = fl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    enq_valid = 1'b0;
    enq_pc    = '0;
    enq_instr = '0;
    deq_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic ordering
    drive(1'b1, 32'h100, 32'h0050_0093, 1'b1, 1'b0);
    drive(1'b1, 32'h104, 32'h00A0_8113, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    idle(1);

    // Fill to full, fifth offer must be dropped
    for (int i = 0; i < 5; i++) drive(1'b1, 32'h200 + 32'(4 * i), $urandom, 1'b0, 1'b0);
    // Full with simultaneous dequeue: only the dequeue happens
    drive(1'b1, 32'h300, $urandom, 1'b1, 1'b0);
    idle(1);
    // Flush priority over same-cycle enqueue and dequeue with count=3
    drive(1'b1, 32'h400, $urandom, 1'b1, 1'b1);
    idle(2);

    // Wrap-around streaming
    for (int i = 0; i < 10; i++) drive(1'b1, 32'h100 + 32'(4 * i), $urandom, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    idle(1);

    // Asynchronous reset between edges with two entries held
    drive(1'b1, 32'h500, $urandom, 1'b0, 1'b0);
    drive(1'b1, 32'h504, $urandom, 1'b0, 1'b0);
    idle(1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_count", 64'(count), 64'd0);
    check("async_rst_deq_valid", 64'(deq_valid), 64'd0);
    check("async_rst_deq_instr", 64'(deq_instr), 64'(NOP));
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // Random traffic, alternating between fill-biased and drain-biased phases
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 400; i++) begin
        drive($urandom_range(0, 3) != 0, $urandom, $urandom,
              (p % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
              $urandom_range(0, 59) == 0);
      end
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_fetch_queue
